// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: warm-up hold, load-use stalls, branch flushes,
// memory-wait freeze with timeout, and saturating performance counters.
module hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        S_INIT   = 2'b00,
        S_RUN    = 2'b01,
        S_FREEZE = 2'b10,
        S_ERR    = 2'b11
    } state_t;

    state_t      cur, nxt;
    logic [7:0]  init_cnt;
    logic [15:0] tmo_cnt;
    logic [16:0] tmo_inc;
    logic        rs_is_src, rt_is_src, hazard;
    logic        run_eval, do_flush, do_stall;

    assign state   = cur;
    assign tmo_inc = {1'b0, tmo_cnt} + 17'd1;

    always_comb begin
        rs_is_src = 1'b0;
        rt_is_src = 1'b0;
        case (id_opcode)
            6'b000000, 6'b101011: begin
                rs_is_src = 1'b1;
                rt_is_src = 1'b1;
            end
            6'b001000, 6'b001100, 6'b001101,
            6'b001110, 6'b001001, 6'b100011: rs_is_src = 1'b1;
            default: ;
        endcase
    end

    assign hazard = ex_mem_read && (ex_rt != '0) &&
                    ((rs_is_src && (ex_rt == id_rs)) || (rt_is_src && (ex_rt == id_rt)));

    always_comb begin
        nxt         = cur;
        run_eval    = 1'b0;
        do_flush    = 1'b0;
        do_stall    = 1'b0;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_we     = 1'b0;
        idex_bubble = 1'b0;
        exmem_we    = 1'b0;
        case (cur)
            S_INIT:   if (init_cnt == 8'(INIT_CYCLES - 1)) nxt = S_RUN;
            S_RUN:    if (!mem_ready) nxt = S_FREEZE;
                      else            run_eval = 1'b1;
            S_FREEZE: begin
                if (mem_ready) begin
                    nxt      = S_RUN;
                    run_eval = 1'b1;
                end else if (tmo_inc >= 17'(MEM_TIMEOUT)) begin
                    nxt = S_ERR;
                end
            end
            default: ;
        endcase
        // The freeze-exit cycle shares the RUN decisions below the mem_ready check
        if (run_eval) begin
            if (ex_branch_taken) begin
                {pc_we, ifid_we, idex_we, exmem_we} = '1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                do_flush    = 1'b1;
            end else if (hazard) begin
                idex_we     = 1'b1;
                idex_bubble = 1'b1;
                exmem_we    = 1'b1;
                do_stall    = 1'b1;
            end else begin
                {pc_we, ifid_we, idex_we, exmem_we} = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= S_INIT;
            init_cnt    <= '0;
            tmo_cnt     <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            freeze_cnt  <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_INIT) init_cnt <= init_cnt + 8'd1;
            if (cur == S_RUN && !mem_ready) begin
                tmo_cnt <= 16'd1;
            end else if (cur == S_FREEZE) begin
                tmo_cnt <= mem_ready ? '0 : tmo_inc[15:0];
            end
            if (cur == S_FREEZE && nxt == S_ERR) mem_timeout <= 1'b1;
            if (do_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (do_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (cur == S_FREEZE && freeze_cnt != '1) freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned INIT = 4;
    localparam int unsigned TMO  = 4;
    localparam int unsigned CW   = 4;
    localparam int          SAT  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    id_opcode;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_mem_read, ex_branch_taken, mem_ready;
    logic          pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we;
    logic [1:0]    state;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.INIT_CYCLES(INIT), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we), .state(state),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .freeze_cnt(freeze_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: 0 INIT, 1 RUN, 2 FREEZE, 3 ERR; m_low counts consecutive mem_ready-low cycles
    int m_st, m_init, m_low, m_stall, m_flush, m_freeze;
    bit m_tmo;

    function automatic void model_reset();
        m_st = 0; m_init = 0; m_low = 0;
        m_stall = 0; m_flush = 0; m_freeze = 0; m_tmo = 1'b0;
    endfunction

    function automatic int sat(int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    function automatic bit m_hazard();
        bit rs_read, rt_read;
        rt_read = (id_opcode == 6'd0) || (id_opcode == 6'd43);
        rs_read = rt_read || (id_opcode inside {6'd8, 6'd12, 6'd13, 6'd14, 6'd9, 6'd35});
        if (!ex_mem_read || ex_rt == 5'd0) return 1'b0;
        return (rs_read && ex_rt == id_rs) || (rt_read && ex_rt == id_rt);
    endfunction

    // {state, mem_timeout, pc, ifid, flush, idex, bubble, exmem, stall, flush, freeze}
    function automatic logic [20:0] exp_vec();
        logic [5:0] en;
        en = '0;
        if ((m_st == 1 || m_st == 2) && mem_ready) begin
            if (ex_branch_taken)  en = 6'b111111;
            else if (m_hazard())  en = 6'b000111;
            else                  en = 6'b110101;
        end
        return {2'(m_st), m_tmo, en, 4'(m_stall), 4'(m_flush), 4'(m_freeze)};
    endfunction

    function automatic logic [20:0] got_vec();
        return {state, mem_timeout, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
                exmem_we, stall_cnt, flush_cnt, freeze_cnt};
    endfunction

    function automatic void model_step();
        bit hz;
        if (!rst_n) return;
        hz = m_hazard();
        case (m_st)
            0: begin
                m_init++;
                if (m_init == INIT) m_st = 1;
            end
            1, 2: begin
                if (m_st == 2) m_freeze = sat(m_freeze);
                if (mem_ready) begin
                    m_st = 1; m_low = 0;
                    if (ex_branch_taken) m_flush = sat(m_flush);
                    else if (hz)         m_stall = sat(m_stall);
                end else begin
                    m_low++;
                    if (m_st == 1) m_st = 2;
                    else if (m_low >= TMO) begin m_st = 3; m_tmo = 1'b1; end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        id_opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic warm();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (INIT) tick();
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (got_vec() !== '0) begin
            n_fail++; $display("FAIL reset_values got %h exp 0", got_vec());
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #3;
            n_chk++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL init_seq cyc %0d got %h exp %h", i, got_vec(), exp_vec());
            end
            n_chk++;
            if (i < 4 && {state, pc_we} !== 3'b000) begin
                n_fail++; $display("FAIL init_hold cyc %0d got st=%b pc_we=%b exp st=00 pc_we=0", i, state, pc_we);
            end else if (i >= 4 && {state, pc_we, ifid_we, idex_we, exmem_we} !== 6'b011111) begin
                n_fail++; $display("FAIL init_run cyc %0d got st=%b en=%b%b%b%b exp st=01 en=1111",
                                   i, state, pc_we, ifid_we, idex_we, exmem_we);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        warm();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_opcode = 6'b000000; id_rt = 5'd5; id_rs = 5'd1;
        #3;
        n_chk++;
        if (got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL load_use got %h exp %h", got_vec(), exp_vec());
        end
        n_chk++;
        if ({pc_we, ifid_we, idex_bubble} !== 3'b001) begin
            n_fail++; $display("FAIL load_use_ctl got %b exp 001", {pc_we, ifid_we, idex_bubble});
        end
        tick();
        ex_mem_read = 1'b0;
        #3;
        n_chk++;
        if ({stall_cnt, pc_we, idex_bubble} !== {4'd1, 2'b10}) begin
            n_fail++; $display("FAIL load_use_after got stall=%0d pc=%b bub=%b exp stall=1 pc=1 bub=0",
                               stall_cnt, pc_we, idex_bubble);
        end
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_opcode = 6'b001000; id_rt = 5'd5; id_rs = 5'd3;
        #3;
        n_chk++;
        if ({pc_we, idex_bubble} !== 2'b10 || got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL addi_no_stall got %h exp %h", got_vec(), exp_vec());
        end
        tick();
        #3;
        n_chk++;
        if (stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL addi_stall_cnt got %0d exp 1", stall_cnt);
        end
    endtask

    task automatic test_branch_over_hazard();
        warm();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_opcode = 6'b000000; id_rt = 5'd5; id_rs = 5'd1;
        ex_branch_taken = 1'b1;
        #3;
        n_chk++;
        if ({pc_we, ifid_flush, idex_bubble} !== 3'b111 || got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL branch_flush got %h exp %h", got_vec(), exp_vec());
        end
        tick();
        set_idle();
        #3;
        n_chk++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
            n_fail++; $display("FAIL branch_cnts got flush=%0d stall=%0d exp flush=1 stall=0",
                               flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_zero_reg();
        warm();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_opcode = 6'b000000; id_rt = 5'd0; id_rs = 5'd0;
        #3;
        n_chk++;
        if ({pc_we, idex_bubble} !== 2'b10 || got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL zero_reg got %h exp %h", got_vec(), exp_vec());
        end
        tick();
        #3;
        n_chk++;
        if (stall_cnt !== 4'd0) begin
            n_fail++; $display("FAIL zero_reg_cnt got %0d exp 0", stall_cnt);
        end
    endtask

    task automatic test_freeze_recover();
        warm();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_chk++;
            if ({pc_we, ifid_we, idex_we, exmem_we} !== 4'b0000 || got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL freeze cyc %0d got %h exp %h", i, got_vec(), exp_vec());
            end
            tick();
        end
        mem_ready = 1'b1;
        #3;
        n_chk++;
        if ({state, pc_we} !== 3'b101 || got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL freeze_exit got %h exp %h", got_vec(), exp_vec());
        end
        tick();
        #3;
        n_chk++;
        if ({state, mem_timeout, freeze_cnt} !== {2'b01, 1'b0, 4'd3}) begin
            n_fail++; $display("FAIL freeze_resume got st=%b to=%b frz=%0d exp st=01 to=0 frz=3",
                               state, mem_timeout, freeze_cnt);
        end
    endtask

    task automatic test_timeout_err();
        warm();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #3;
            n_chk++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL timeout cyc %0d got %h exp %h", i, got_vec(), exp_vec());
            end
            tick();
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_chk++;
            if ({state, mem_timeout, pc_we, freeze_cnt} !== {2'b11, 1'b1, 1'b0, 4'd3}) begin
                n_fail++; $display("FAIL err_hold cyc %0d got st=%b to=%b pc=%b frz=%0d exp st=11 to=1 pc=0 frz=3",
                                   i, state, mem_timeout, pc_we, freeze_cnt);
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (got_vec() !== '0) begin
            n_fail++; $display("FAIL async_reset got %h exp 0", got_vec());
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        warm();
        for (int i = 0; i < 40; i++) begin
            set_idle();
            if (i % 2 == 0) begin
                ex_mem_read = 1'b1; ex_rt = 5'd7; id_opcode = 6'b101011; id_rt = 5'd7; id_rs = 5'd2;
            end
            if (i >= 20 && i % 2 == 1) ex_branch_taken = 1'b1;
            #3;
            n_chk++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL saturate cyc %0d got %h exp %h", i, got_vec(), exp_vec());
            end
            tick();
        end
        #3;
        n_chk++;
        if ({stall_cnt, flush_cnt} !== {4'd15, 4'd10}) begin
            n_fail++; $display("FAIL saturate_end got stall=%0d flush=%0d exp stall=15 flush=10",
                               stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [10];
        ops = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd14, 6'd9, 6'd35, 6'd43, 6'd2, 6'd63};
        warm();
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59 && m_st == 3) warm();
            id_opcode       = ops[$urandom_range(0, 9)];
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_ready       = ($urandom_range(0, 5) != 0);
            #3;
            n_chk++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d got %h exp %h", i, got_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_branch_over_hazard();
        test_zero_reg();
        test_freeze_recover();
        test_timeout_err();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
